// File: rtl/lut_mult_accumulator.sv
// lut_mult_accumulator: sums N_TERMS unsigned products from the LUT multiplier
// into one ACC_W-bit result with a sticky overflow flag, handed downstream on a
// valid/ready port. Optional macro SATURATE_EN clamps the sum at all-ones on
// carry instead of wrapping.
module lut_mult_accumulator #(
  parameter int unsigned PROD_W  = 16,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned N_TERMS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t           state, state_next;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic             accept;
  logic             consume;

  // Widened sum so the carry out of ACC_W is visible.
  always_comb begin
    sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  // Next-state logic: flush wins, otherwise handshake-driven transitions.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && (cnt == LAST)) state_next = DONE;
        DONE:    if (consume) state_next = ACCUM;
        default: state_next = ACCUM;
      endcase
    end
  end

  // Output and handshake decode; outputs come straight from registers.
  always_comb begin
    in_ready  = (state == ACCUM) && !flush && !rst;
    out_valid = (state == DONE);
    out_sum   = acc;
    out_ovf   = ovf;
    accept    = in_valid && in_ready;
    consume   = (state == DONE) && out_ready;
  end

  // Accumulator datapath: clear on flush or consume, add on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (flush) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (consume) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
`ifdef SATURATE_EN
      acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
      acc <= sum[ACC_W-1:0];
`endif
      if (sum[ACC_W]) ovf <= 1'b1;
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lut_mult_accumulator.sv
// tb_lut_mult_accumulator: four instances (N=4/W=24, N=4/W=17, N=8/W=24,
// N=1/W=24) driven by directed and random steps, checked against a model that
// tracks the plain integer total of accepted products.
module tb_lut_mult_accumulator;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] iv, fl, ordy, ir, ov, oo;
  logic [3:0][15:0] ip;
  logic [23:0] s0, s2, s3;
  logic [16:0] s1;

  int unsigned NT [4] = '{4, 4, 8, 1};
  int unsigned WD [4] = '{24, 17, 24, 24};

  longint unsigned tot [4];
  int unsigned     n   [4];
  bit              md  [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lut_mult_accumulator #(.PROD_W(16), .ACC_W(24), .N_TERMS(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_prod(ip[0]),
    .flush(fl[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(s0), .out_ovf(oo[0]));
  lut_mult_accumulator #(.PROD_W(16), .ACC_W(17), .N_TERMS(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_prod(ip[1]),
    .flush(fl[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(s1), .out_ovf(oo[1]));
  lut_mult_accumulator #(.PROD_W(16), .ACC_W(24), .N_TERMS(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_prod(ip[2]),
    .flush(fl[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(s2), .out_ovf(oo[2]));
  lut_mult_accumulator #(.PROD_W(16), .ACC_W(24), .N_TERMS(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_prod(ip[3]),
    .flush(fl[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_sum(s3), .out_ovf(oo[3]));

  function automatic logic [23:0] osum(int d);
    case (d)
      0:       return s0;
      1:       return {7'd0, s1};
      2:       return s2;
      default: return s3;
    endcase
  endfunction

  function automatic logic [23:0] exp_acc(int d);
    longint unsigned lim = 64'd1 << WD[d];
    if (tot[d] < lim) return 24'(tot[d]);
`ifdef SATURATE_EN
    return 24'(lim - 1);
`else
    return 24'(tot[d] % lim);
`endif
  endfunction

  function automatic logic exp_ovf(int d);
    return tot[d] >= (64'd1 << WD[d]);
  endfunction

  task automatic clear(int d);
    tot[d] = 0;
    n[d]   = 0;
    md[d]  = 0;
  endtask

  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // One clock on instance d; entered and left at posedge+1.
  task automatic cycle(int d, bit v, logic [15:0] p, bit f, bit r);
    bit acc_e, con_e;
    iv[d] = v; ip[d] = p; fl[d] = f; ordy[d] = r;
    #1;
    chk("in_ready", d, ir[d], !md[d] && !f);
    acc_e = v && !md[d] && !f;
    con_e = md[d] && r && !f;
    if (f || con_e) begin
      clear(d);
    end else if (acc_e) begin
      tot[d] += p;
      n[d]++;
      if (n[d] == NT[d]) begin
        md[d] = 1;
        n[d]  = 0;
      end
    end
    @(posedge clk); #1;
    iv[d] = 0; fl[d] = 0; ordy[d] = 0;
    chk("out_valid", d, ov[d], md[d]);
    chk("out_sum", d, osum(d), exp_acc(d));
    chk("out_ovf", d, oo[d], exp_ovf(d));
  endtask

  initial begin
    int k;
    iv = '0; fl = '0; ordy = '0; ip = '0;
    for (int d = 0; d < 4; d++) clear(d);
    rst = 1'b1;
    #2;
    for (int d = 0; d < 4; d++) begin
      chk("rst_in_ready", d, ir[d], 0);
      chk("rst_out_valid", d, ov[d], 0);
      chk("rst_out_sum", d, osum(d), 0);
    end
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic sum
    cycle(0, 1, 16'h00FE, 0, 0);
    cycle(0, 1, 16'h0100, 0, 0);
    cycle(0, 1, 16'h0002, 0, 0);
    cycle(0, 1, 16'h0000, 0, 0);
    chk("basic_sum", 0, s0, 24'h000200);
    chk("basic_valid", 0, ov[0], 1);

    // Backpressure: hold five cycles, then consume
    for (int i = 0; i < 5; i++) cycle(0, 1, 16'h0005, 0, 0);
    chk("bp_sum", 0, s0, 24'h000200);
    cycle(0, 1, 16'h0005, 0, 1);
    cycle(0, 1, 16'h0005, 0, 0);
    chk("bp_restart", 0, s0, 24'h000005);
    for (int i = 0; i < 3; i++) cycle(0, 1, 16'h0001, 0, 0);
    chk("bp_sum2", 0, s0, 24'h000008);
    cycle(0, 0, 16'h0000, 0, 1);

    // Overflow on the 17-bit instance
    for (int i = 0; i < 4; i++) cycle(1, 1, 16'hFFFF, 0, 0);
`ifdef SATURATE_EN
    chk("ovf_sum", 1, s1, 17'h1FFFF);
`else
    chk("ovf_sum", 1, s1, 17'h1FFFC);
`endif
    chk("ovf_flag", 1, oo[1], 1);
    cycle(1, 0, 16'h0000, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 1, 16'h0003, 0, 0);
    chk("ovf_cleared", 1, oo[1], 0);
    chk("ovf_next_sum", 1, s1, 17'h0000C);
    cycle(1, 0, 16'h0000, 0, 1);

    // Flush mid-accumulation, then flush a pending result
    cycle(0, 1, 16'h0010, 0, 0);
    cycle(0, 1, 16'h0020, 0, 0);
    cycle(0, 1, 16'h0040, 1, 0);
    chk("flush_cleared", 0, s0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 16'h0001, 0, 0);
    chk("flush_sum", 0, s0, 24'h000004);
    cycle(0, 0, 16'h0000, 1, 1);
    chk("flush_drop", 0, ov[0], 0);

    // Async reset while a result is pending
    for (int i = 0; i < 4; i++) cycle(0, 1, 16'h0101, 0, 0);
    chk("pre_rst_valid", 0, ov[0], 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 0, ov[0], 0);
    chk("arst_out_sum", 0, s0, 0);
    chk("arst_out_ovf", 0, oo[0], 0);
    chk("arst_in_ready", 0, ir[0], 0);
    for (int d = 0; d < 4; d++) clear(d);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    cycle(0, 0, 16'h0000, 0, 0);

    // Bubbly input on the 8-term instance
    k = 0;
    while (!md[2] && k < 200) begin
      cycle(2, 1'($urandom_range(0, 1)), 16'h1234, 0, 0);
      k++;
    end
    chk("bubbly_done", 2, ov[2], 1);
    chk("bubbly_sum", 2, s2, 24'h0091A0);
    cycle(2, 0, 16'h0000, 0, 1);

    // Single-term instance
    for (int i = 0; i < 30; i++)
      cycle(3, 1'($urandom_range(0, 1)), 16'($urandom), 0, 1'($urandom_range(0, 1)));

    // Random mix with backpressure and occasional flush
    for (int i = 0; i < 300; i++) begin
      int d = i % 2;
      cycle(d, 1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 3) == 0 ? 16'hFFFF : $urandom),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lut_mult_accumulator.md
Name: lut_mult_accumulator

Overview:
Downstream consumer of the constant-coefficient LUT multiplier. It takes the 16-bit products C, one per handshake, and accumulates a fixed number of them into one wide sum, as in a dot-product or FIR tap sum. It also flags overflow and presents the result on a valid/ready output port. The block is the first clocked stage after the purely combinational multiplier.

Parameters:
PROD_W, 16, width of incoming product (matches multiplier output C)
ACC_W, 24, accumulator/result width; must be >= PROD_W
N_TERMS, 8, products summed per result; must be >= 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  product on in_prod is valid
in_ready  output  1  block accepts a product this cycle
in_prod  input  PROD_W  unsigned product from the LUT multiplier
flush  input  1  synchronous abort of the current accumulation
out_valid  output  1  out_sum/out_ovf hold a completed result
out_ready  input  1  downstream accepts the result
out_sum  output  ACC_W  accumulated sum of N_TERMS products
out_ovf  output  1  sticky: a carry out of ACC_W occurred during this result

Behaviour:
- State: acc[ACC_W-1:0], cnt[clog2(N_TERMS+1)-1:0], ovf, FSM {ACCUM, DONE}.
- Reset (async, any time, including mid-accumulation or mid-DONE):
  - FSM=ACCUM, acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_ovf=0.
  - in_ready=0 while rst is high.
  - Partial sums are discarded.
- in_ready = (FSM==ACCUM) && !flush && !rst. This is combinational from state and flush only, never from in_valid.
- out_sum = acc, out_ovf = ovf, out_valid = (FSM==DONE). All are registered, with no combinational path from inputs.
- ACCUM state, when in_valid && in_ready:
  - acc <= acc + zero-extend(in_prod), modulo 2^ACC_W.
  - If the ACC_W+1-bit sum has its carry set, ovf <= 1. The flag is sticky until the result is consumed.
  - cnt <= cnt+1.
  - If cnt == N_TERMS-1 at the accept, move to DONE and set cnt <= 0.
- Latency: out_valid rises the cycle after the N_TERMS-th accept and already carries the final sum.
- N_TERMS=1: every accepted product goes directly to DONE.
- ACCUM with in_valid low: hold all state. No timeout.
- DONE state:
  - in_ready=0; upstream is stalled.
  - out_sum and out_ovf stay stable until out_ready is high.
  - On out_valid && out_ready: acc <= 0, ovf <= 0, FSM <= ACCUM. in_ready is 1 on the following cycle.
  - This gives exactly one bubble cycle per result; there is no same-cycle bypass.
- flush (synchronous, highest priority after rst), in either state:
  - acc <= 0, cnt <= 0, ovf <= 0, FSM <= ACCUM.
  - A product offered in the same cycle is not accepted (in_ready is 0).
  - A pending DONE result is dropped, even if out_ready is high the same cycle.
- Inputs are unsigned; no sign handling.

Optional Feature:
SATURATE_EN
- Defined: on carry out of ACC_W, acc <= all-ones (2^ACC_W - 1) and ovf <= 1. Further adds keep acc at all-ones.
- Undefined: acc wraps modulo 2^ACC_W and ovf <= 1.
- Handshake, latency and FSM are identical in both builds.

Test Plan:
1. Basic sum (N_TERMS=4, ACC_W=24): in_valid held high, in_prod = 0x00FE, 0x0100, 0x0002, 0x0000. Required: out_valid the cycle after the 4th accept, out_sum=0x000200, out_ovf=0; in_ready=0 while out_valid is high.
2. Backpressure: the same stream with out_ready low for 5 cycles after out_valid. Required: out_sum stable at 0x000200, in_ready=0 throughout; after the out_ready pulse, in_ready=1 on the next cycle and a new sum starts from 0.
3. Overflow (N_TERMS=4, ACC_W=17): in_prod = 0xFFFF x4. Required: without SATURATE_EN, out_sum=0x1FFFC and out_ovf=1; with SATURATE_EN, out_sum=0x1FFFF and out_ovf=1; the next result clears out_ovf.
4. Flush: accept 2 products (0x0010, 0x0020), then raise flush together with in_valid and in_prod=0x0040. Required: in_ready=0 that cycle and the product is not accepted. Then feed 4 products of 0x0001. Required: out_sum=0x000004.
5. Async reset mid-DONE: assert rst between clock edges while out_valid=1. Required: out_valid, out_sum and out_ovf go to 0 immediately; in_ready=0 during rst and 1 on the first cycle after release.
6. Bubbly input (N_TERMS=8): in_valid toggled randomly with in_prod=0x1234. Required: out_sum=0x0091A0 only after exactly 8 accepts; cnt does not advance on idle cycles.
